// File: rtl/vpe_pkg.sv
// rtl/vpe_pkg.sv - shared types and signed add/saturate helpers for the psum cache
package vpe_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_ACCU  = 2'b01,
    CMD_LOAD  = 2'b10,
    CMD_DRAIN = 2'b11
  } psum_cmd_e;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'b000,
    ST_ACCU  = 3'b001,
    ST_LOAD  = 3'b010,
    ST_DRAIN = 3'b011,
    ST_IDLE  = 3'b100
  } psum_state_e;

  // Operands arrive sign-extended to 64 bits; w is the stored width (w <= 62).
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic sat_ovf(input logic signed [63:0] a, input logic signed [63:0] b,
                                   input int w);
    logic signed [63:0] s;
    s = a + b;
    return (s > sat_max(w)) || (s < sat_min(w));
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w, input logic sat);
    logic signed [63:0] s;
    s = a + b;
    if (sat && (s > sat_max(w))) return sat_max(w);
    if (sat && (s < sat_min(w))) return sat_min(w);
    return s;
  endfunction

endpackage

// File: rtl/vpe_psum_lane.sv
// rtl/vpe_psum_lane.sv - one lane of psum storage with saturating accumulate and sticky overflow
module vpe_psum_lane
  import vpe_pkg::*;
#(
  parameter int PSUM_WIDTH = 32,
  parameter int I_WIDTH    = 16,
  parameter int DEPTH      = 16,
  parameter int SATURATE   = 1,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic                  i_clr,
  input  logic                  i_acc,
  input  logic                  i_ld,
  input  logic                  i_ovf_clr,
  input  logic [I_WIDTH-1:0]    i_in,
  input  logic [PSUM_WIDTH-1:0] i_ld_data,
  output logic [PSUM_WIDTH-1:0] o_data,
  output logic                  o_ovf
);

  logic [PSUM_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_ovf;
  logic signed [63:0]    w_a;
  logic signed [63:0]    w_b;
  logic [PSUM_WIDTH-1:0] w_sum;
  logic                  w_ovf;

  assign o_data = r_mem[i_idx];
  assign o_ovf  = r_ovf;
  assign w_a    = {{(64-PSUM_WIDTH){o_data[PSUM_WIDTH-1]}}, o_data};
  assign w_b    = {{(64-I_WIDTH){i_in[I_WIDTH-1]}}, i_in};
  assign w_sum  = PSUM_WIDTH'(sat_add(w_a, w_b, PSUM_WIDTH, SATURATE != 0));
  assign w_ovf  = sat_ovf(w_a, w_b, PSUM_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_clr)      r_mem[i_idx] <= '0;
      else if (i_acc) r_mem[i_idx] <= w_sum;
      else if (i_ld)  r_mem[i_idx] <= i_ld_data;
      if (i_ovf_clr)            r_ovf <= 1'b0;
      else if (i_acc && w_ovf)  r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/vpe_psum_cache_mc.sv
// rtl/vpe_psum_cache_mc.sv - multi-lane psum cache: pass FSM, index, handshakes, lane array
module vpe_psum_cache_mc
  import vpe_pkg::*;
#(
  parameter int PSUM_WIDTH = 32,
  parameter int I_WIDTH    = 16,
  parameter int LANES      = 4,
  parameter int DEPTH      = 16,
  parameter int SATURATE   = 1,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [IDX_W-1:0]            cmd_last,
  input  logic                        cmd_zero,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*I_WIDTH-1:0]    in_data,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [LANES*PSUM_WIDTH-1:0] load_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*PSUM_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic [IDX_W-1:0]            idx,
  output logic [LANES-1:0]            ovf_sticky
);

  psum_state_e      r_state, w_state_nxt;
  psum_cmd_e        w_cmd;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, r_len, w_len_nxt, w_cmd_last;
  logic             r_zero, w_zero_nxt;
  logic             w_beat, w_clr, w_acc, w_ld, w_ovf_clr;

  assign w_cmd      = psum_cmd_e'(cmd_op);
  assign w_cmd_last = ({1'b0, cmd_last} > (IDX_W+1)'(DEPTH-1)) ? IDX_W'(DEPTH-1) : cmd_last;
  // CLEAR always starts at index 0, so its first cycle is the one with idx 0.
  assign w_ovf_clr  = (r_state == ST_CLEAR) && (r_idx == '0);
  assign busy       = (r_state != ST_IDLE);
  assign idx        = r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_zero_nxt  = r_zero;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    load_ready  = 1'b0;
    out_valid   = 1'b0;
    w_beat      = 1'b0;
    w_clr       = 1'b0;
    w_acc       = 1'b0;
    w_ld        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (w_cmd)
            CMD_CLEAR: w_state_nxt = ST_CLEAR;
            CMD_ACCU:  w_state_nxt = ST_ACCU;
            CMD_LOAD:  w_state_nxt = ST_LOAD;
            CMD_DRAIN: w_state_nxt = ST_DRAIN;
            default:   w_state_nxt = ST_IDLE;
          endcase
          w_len_nxt  = w_cmd_last;
          w_zero_nxt = cmd_zero;
          w_idx_nxt  = '0;
        end
      end
      ST_CLEAR: begin
        w_beat = 1'b1;
        w_clr  = 1'b1;
      end
      ST_ACCU: begin
        in_ready = 1'b1;
        w_beat   = in_valid;
        w_acc    = in_valid;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        w_beat     = load_valid;
        w_ld       = load_valid;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        w_beat    = out_ready;
        w_clr     = out_ready && r_zero;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_beat) begin
      if (r_idx == r_len) begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vpe_psum_lane #(
      .PSUM_WIDTH(PSUM_WIDTH),
      .I_WIDTH   (I_WIDTH),
      .DEPTH     (DEPTH),
      .SATURATE  (SATURATE),
      .IDX_W     (IDX_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_idx    (r_idx),
      .i_clr    (w_clr),
      .i_acc    (w_acc),
      .i_ld     (w_ld),
      .i_ovf_clr(w_ovf_clr),
      .i_in     (in_data[g*I_WIDTH +: I_WIDTH]),
      .i_ld_data(load_data[g*PSUM_WIDTH +: PSUM_WIDTH]),
      .o_data   (out_data[g*PSUM_WIDTH +: PSUM_WIDTH]),
      .o_ovf    (ovf_sticky[g])
    );
  end

endmodule

// File: tb/tb_vpe_psum_cache_mc.sv
// tb/tb_vpe_psum_cache_mc.sv - self-checking bench for vpe_psum_cache_mc
module tb_vpe_psum_cache_mc;
  import vpe_pkg::*;

  localparam int PW = 32, IW = 16, L = 4, D = 16, XW = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk, rst;
  logic cmd_valid, cmd_zero, in_valid, load_valid, out_ready;
  logic [1:0] cmd_op;
  logic [XW-1:0] cmd_last;
  logic [L*IW-1:0] in_data;
  logic [L*PW-1:0] load_data;
  logic cmd_ready, in_ready, load_ready, out_valid, busy;
  logic [L*PW-1:0] out_data;
  logic [XW-1:0] idx;
  logic [L-1:0] ovf_sticky;
  logic cmd_ready_w, in_ready_w, load_ready_w, out_valid_w, busy_w;
  logic [L*PW-1:0] out_data_w;
  logic [XW-1:0] idx_w;
  logic [L-1:0] ovf_sticky_w;

  vpe_psum_cache_mc #(.PSUM_WIDTH(PW), .I_WIDTH(IW), .LANES(L), .DEPTH(D), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_last(cmd_last), .cmd_zero(cmd_zero), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .idx(idx),
    .ovf_sticky(ovf_sticky));

  vpe_psum_cache_mc #(.PSUM_WIDTH(PW), .I_WIDTH(IW), .LANES(L), .DEPTH(D), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w), .cmd_op(cmd_op),
    .cmd_last(cmd_last), .cmd_zero(cmd_zero), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .load_valid(load_valid), .load_ready(load_ready_w), .load_data(load_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .busy(busy_w),
    .idx(idx_w), .ovf_sticky(ovf_sticky_w));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_tests = 0, n_fail = 0;
  logic [PW-1:0] m_mem [L][D];
  logic [L-1:0]  m_ovf;
  logic [L*IW-1:0] in_q [$];
  logic [L*PW-1:0] ld_q [$];
  logic            rdy_q [$];
  logic [L*PW-1:0] drained_q [$];

  typedef struct {
    logic [PW-1:0] init;
    logic [IW-1:0] inc;
    logic [PW-1:0] exp_sat;
    logic [PW-1:0] exp_wrap;
    logic          ovf;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [L*PW-1:0] row(input int k);
    logic [L*PW-1:0] r;
    for (int l = 0; l < L; l++) r[l*PW +: PW] = m_mem[l][k];
    return r;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < L; l++) for (int k = 0; k < D; k++) m_mem[l][k] = '0;
    m_ovf = '0;
  endtask

  // Runs one whole pass from command issue to return to IDLE, checking every cycle.
  task automatic run_pass(input logic [1:0] op, input logic [XW-1:0] last, input logic zero,
                          input logic noise);
    int len, k, stall, guard;
    logic go;
    logic [L*IW-1:0] din;
    logic [L*PW-1:0] ldin;
    longint a, b, s;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_last = last; cmd_zero = zero;
    @(negedge clk);
    cmd_valid = 1'b0;
    len = (int'(last) > D - 1) ? D - 1 : int'(last);
    drained_q.delete();
    k = 0; stall = 0; guard = 0;
    while (k <= len && guard < 1000) begin
      guard++;
      chk("busy_in_pass", busy, 1);
      chk("idx_in_pass", idx, k);
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("in_ready", in_ready, op == CMD_ACCU);
      chk("load_ready", load_ready, op == CMD_LOAD);
      chk("out_valid", out_valid, op == CMD_DRAIN);
      if (op == CMD_DRAIN) chk("drain_data", out_data, row(k));
      if (op == CMD_CLEAR) go = 1'b1;
      else if (rdy_q.size() > 0) go = rdy_q.pop_front();
      else go = ($urandom_range(0, 3) != 0) || (stall >= 4);
      din  = {$urandom, $urandom};
      ldin = {$urandom, $urandom, $urandom, $urandom};
      if (go && op == CMD_ACCU && in_q.size() > 0) din = in_q.pop_front();
      if (go && op == CMD_LOAD && ld_q.size() > 0) ldin = ld_q.pop_front();
      in_valid   = (op == CMD_ACCU) ? go : noise;
      in_data    = din;
      load_valid = (op == CMD_LOAD) && go;
      load_data  = ldin;
      out_ready  = (op == CMD_DRAIN) && go;
      if (noise) begin
        cmd_valid = 1'b1;
        cmd_op    = CMD_ACCU;
      end
      if (go) begin
        for (int l = 0; l < L; l++) begin
          case (op)
            CMD_CLEAR: begin
              if (k == 0) m_ovf = '0;
              m_mem[l][k] = '0;
            end
            CMD_ACCU: begin
              a = longint'($signed(m_mem[l][k]));
              b = longint'($signed(din[l*IW +: IW]));
              s = a + b;
              if (s > MAXV || s < MINV) m_ovf[l] = 1'b1;
              if (s > MAXV) s = MAXV;
              if (s < MINV) s = MINV;
              m_mem[l][k] = s[PW-1:0];
            end
            CMD_LOAD: m_mem[l][k] = ldin[l*PW +: PW];
            default: ;
          endcase
        end
        if (op == CMD_DRAIN) begin
          drained_q.push_back(row(k));
          if (zero) for (int l = 0; l < L; l++) m_mem[l][k] = '0;
        end
        k++;
        stall = 0;
      end else begin
        stall++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; load_valid = 1'b0; out_ready = 1'b0; cmd_valid = 1'b0;
    chk("busy_end", busy, 0);
    chk("idx_end", idx, 0);
    chk("ovf_model", ovf_sticky, m_ovf);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_last = '0; cmd_zero = 1'b0;
    in_valid = 1'b0; in_data = '0; load_valid = 1'b0; load_data = '0; out_ready = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", idx, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf_sticky, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{32'h7FFFFFF0, 16'h0020, 32'h7FFFFFFF, 32'h80000010, 1'b1};
    vecs[1] = '{32'h80000010, 16'hFFE0, 32'h80000000, 32'h7FFFFFF0, 1'b1};
    vecs[2] = '{32'h00000005, 16'hFFFD, 32'h00000002, 32'h00000002, 1'b0};
    vecs[3] = '{32'h7FFF0000, 16'h7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 16'h8000, 32'hFFFF7FFF, 32'hFFFF7FFF, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 16'h0001, 32'h7FFFFFFF, 32'h80000000, 1'b1};
    vecs[6] = '{32'h80000000, 16'hFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b1};
    vecs[7] = '{32'h80000000, 16'h0001, 32'h80000001, 32'h80000001, 1'b0};
    for (int v = 0; v < 8; v++) begin
      run_pass(CMD_CLEAR, 4'd0, 1'b0, 1'b0);
      ld_q.push_back({L{vecs[v].init}});
      run_pass(CMD_LOAD, 4'd0, 1'b0, 1'b0);
      in_q.push_back({L{vecs[v].inc}});
      run_pass(CMD_ACCU, 4'd0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_sat", v), out_data, {L{vecs[v].exp_sat}});
      chk($sformatf("vec%0d_wrap", v), out_data_w, {L{vecs[v].exp_wrap}});
      chk($sformatf("vec%0d_ovf", v), ovf_sticky, {L{vecs[v].ovf}});
      chk($sformatf("vec%0d_ovf_w", v), ovf_sticky_w, {L{vecs[v].ovf}});
    end
    run_pass(CMD_CLEAR, 4'd0, 1'b0, 1'b0);
    chk("clear_ovf", ovf_sticky, 0);
    chk("clear_ovf_w", ovf_sticky_w, 0);

    run_pass(CMD_CLEAR, 4'd3, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) in_q.push_back({48'd0, 16'(i + 1)});
    run_pass(CMD_ACCU, 4'd3, 1'b0, 1'b0);
    run_pass(CMD_ACCU, 4'd3, 1'b0, 1'b0);
    run_pass(CMD_DRAIN, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) chk("accu_lane0", drained_q[i], {96'd0, 32'(2 * (i + 1))});

    rdy_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_pass(CMD_DRAIN, 4'd2, 1'b0, 1'b0);
    chk("bp_beats", drained_q.size(), 3);
    chk("bp_pattern_used", rdy_q.size(), 0);

    ld_q = '{{L{32'd5}}, {L{32'd6}}, {L{32'd7}}, {L{32'd8}}};
    run_pass(CMD_LOAD, 4'd3, 1'b0, 1'b0);
    run_pass(CMD_DRAIN, 4'd1, 1'b1, 1'b0);
    chk("zr_first0", drained_q[0], {L{32'd5}});
    chk("zr_first1", drained_q[1], {L{32'd6}});
    run_pass(CMD_DRAIN, 4'd3, 1'b0, 1'b0);
    chk("zr_again0", drained_q[0], 0);
    chk("zr_again1", drained_q[1], 0);
    chk("zr_kept2", drained_q[2], {L{32'd7}});
    chk("zr_kept3", drained_q[3], {L{32'd8}});

    run_pass(CMD_LOAD, 4'd3, 1'b0, 1'b1);
    run_pass(CMD_DRAIN, 4'd3, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++)
      run_pass(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    run_pass(CMD_DRAIN, 4'd15, 1'b0, 1'b0);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = CMD_ACCU; cmd_last = 4'd3; cmd_zero = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = {L{16'd7}};
    @(negedge clk);
    chk("mid_idx_before", idx, 1);
    in_data = {L{16'd9}};
    #2 rst = 1'b1;
    #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_load_ready", load_ready, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_idx", idx, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_ovf", ovf_sticky, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    run_pass(CMD_DRAIN, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) chk("post_rst_zero", drained_q[i], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vpe_psum_cache_mc.md
Name: vpe_psum_cache_mc

Overview:
Multi-lane, runtime-length partial-sum cache for the VPU vector processing element. It accumulates LANES parallel input streams into a DEPTH-entry psum buffer, with optional saturation. It supports handshaked bulk load and handshaked, backpressured drain with optional zero-on-read. It sits between the systolic-array output stream and the VPU activation/writeback path.

Parameters:
PSUM_WIDTH, 32, width of each stored psum per lane
I_WIDTH, 16, width of each input element per lane (I_WIDTH <= PSUM_WIDTH)
LANES, 4, number of parallel channels sharing one index
DEPTH, 16, number of psum entries per lane (>= 2)
SATURATE, 1, 1 = clamp on signed overflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when both high
cmd_op  in  2  00 CLEAR, 01 ACCU, 10 LOAD, 11 DRAIN
cmd_last  in  IDX_W  last entry index of the pass (IDX_W = clog2(DEPTH)); pass length is cmd_last+1
cmd_zero  in  1  DRAIN only: zero each entry as it is read
in_valid  in  1  accumulate beat valid
in_ready  out  1  accumulate beat accepted
in_data  in  LANES*I_WIDTH  signed inputs; lane l at [l*I_WIDTH +: I_WIDTH]
load_valid  in  1  load beat valid
load_ready  out  1  load beat accepted
load_data  in  LANES*PSUM_WIDTH  psum values to write
out_valid  out  1  drain beat valid
out_ready  in  1  downstream accepts drain beat
out_data  out  LANES*PSUM_WIDTH  psum values read from entry idx
busy  out  1  state != IDLE
idx  out  IDX_W  current entry index
ovf_sticky  out  LANES  per-lane overflow flag, sticky until CLEAR or reset

Behaviour:
- Reset (async, any state, mid-pass included): state IDLE, idx 0, len_q 0, zero_q 0, all entries 0, ovf_sticky 0. Output values during reset: cmd_ready 1, in_ready 0, load_ready 0, out_valid 0, busy 0, out_data = entry 0 = 0.
- States are IDLE, CLEAR, ACCU, LOAD, DRAIN (2-bit encoding plus IDLE; 3-bit enum).
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On cmd_valid, latch cmd_last into len_q and cmd_zero into zero_q, set idx 0, and go to the state for cmd_op on the next cycle.
  - Commands are never queued; cmd_valid outside IDLE is ignored.
- CLEAR: writes 0 to entry idx in all lanes, one entry per cycle, for len_q+1 cycles. Clears ovf_sticky in its first cycle. No handshake.
- ACCU:
  - in_ready = 1.
  - Each in_valid beat, per lane: entry[idx] <= f(entry[idx] + sign_ext(in_data lane)).
  - The sum is computed at PSUM_WIDTH+1 bits. On signed overflow, ovf_sticky[l] is set. f saturates to the max/min signed PSUM_WIDTH value if SATURATE=1, otherwise truncates.
  - Cycles with in_valid low hold state; there is no timeout.
- LOAD: load_ready = 1. Each load_valid beat writes load_data to entry[idx] in all lanes.
- DRAIN:
  - out_valid = 1.
  - out_data is a combinational read of entry[idx].
  - Beat completes when out_ready = 1. On completion, if zero_q = 1 the entry is written 0.
  - With out_ready low, out_data and idx must stay stable.
- Index advance (ACCU, LOAD, DRAIN on each completed beat; CLEAR every cycle):
  - if idx == len_q: idx <= 0 and state <= IDLE.
  - otherwise idx <= idx+1.
  - idx never exceeds len_q. cmd_last > DEPTH-1 is clamped to DEPTH-1 at latch.
- Latency: single-cycle read-modify-write. A beat at cycle t is visible on out_data / entry contents from t+1.
- Entries above len_q are untouched by any pass.
- out_data is valid to read in every state. It shows entry[idx], used for debug.

Decomposition:
- Package vpe_pkg holds:
  - psum_cmd_e (CLEAR/ACCU/LOAD/DRAIN)
  - psum_state_e
  - a sat_add function (PSUM_WIDTH-generic through parameters passed at call site, or a parameterised class-free macro)
- Sub-module vpe_psum_lane (one per lane, generate loop) owns the storage array, the sat-add datapath and the overflow flag.
- The top owns the FSM, idx, len_q, zero_q and handshakes.

Test Plan:
1. Accumulate wrap: CLEAR last=3, then ACCU last=3 with lane0 inputs 1,2,3,4 run twice. DRAIN last=3 gives lane0 2,4,6,8, and busy drops one cycle after the 4th beat.
2. Saturation: LOAD entry0 lane1 = 0x7FFFFFF0, then ACCU last=0 with input +0x20. With SATURATE=1, entry0 = 0x7FFFFFFF and ovf_sticky[1] = 1. With SATURATE=0, entry0 = 0x80000010 and the flag is still set. A following CLEAR resets the flag.
3. Backpressure: DRAIN last=2 with out_ready pattern 0,0,1,0,1,1. Exactly 3 beats are accepted, out_data and idx are stable while stalled, and IDLE is reached after the 3rd accepted beat.
4. Zero-on-read: LOAD 5,6 then DRAIN last=1 with cmd_zero=1. Reads give 5,6; a second DRAIN gives 0,0. Entries above index 1 are unchanged.
5. Ignored inputs: drive in_valid=1 and cmd_valid=1 during LOAD. Memory holds only load_data and the command is not accepted until IDLE.
6. Mid-pass reset: assert rst asynchronously during the 2nd ACCU beat. All outputs take their reset values before the next clock edge, and a subsequent DRAIN returns all zeros.
